// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule controller: drives an external combinational expansion round
// and stores NUM_ROUNDS+1 round keys. Define KEY_SCHED_REVERSE_READ_EN for last-key-first reads.
module key_schedule_seq #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic [127:0] exp_key,
    output logic [31:0]  exp_rcon,
    input  logic [127:0] exp_subkey,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } state_e;

    state_e       state_q;
    logic [3:0]   round_q;
    logic [127:0] exp_key_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] store_q [NUM_ROUNDS+1];

    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            round_q   <= 4'd0;
            exp_key_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (key_valid) begin
                        store_q[0] <= key_in;
                        exp_key_q  <= key_in;
                        round_q    <= 4'd1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= StExpand;
                    end
                end
                StExpand: begin
                    // key_valid is deliberately not looked at here: no restart mid-expansion.
                    for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
                        if (round_q == 4'(i)) begin
                            store_q[i] <= exp_subkey;
                        end
                    end
                    exp_key_q <= exp_subkey;
                    if (round_q == LastRound) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        exp_rcon = '0;
        if (state_q == StExpand) begin
            exp_rcon = {rcon_byte(round_q), 24'h0};
        end
    end

    always_comb begin
        logic [3:0] sel;
        sel    = '0;
        rd_key = '0;
        if (rd_idx <= LastRound) begin
`ifdef KEY_SCHED_REVERSE_READ_EN
            sel = LastRound - rd_idx;
`else
            sel = rd_idx;
`endif
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
                if (sel == 4'(i)) begin
                    rd_key = store_q[i];
                end
            end
        end
    end

    assign exp_key = exp_key_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq; the AES expansion round is modelled here and fed back
// through exp_key/exp_rcon/exp_subkey. Reads honour KEY_SCHED_REVERSE_READ_EN when defined.
module tb_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic [127:0] exp_key;
    logic [31:0]  exp_rcon;
    logic [127:0] exp_subkey;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FipsR2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZeroR2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0] rc_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    key_schedule_seq #(
        .NUM_ROUNDS(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .exp_key   (exp_key),
        .exp_rcon  (exp_rcon),
        .exp_subkey(exp_subkey),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rc;
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb exp_subkey = expand_round(exp_key, exp_rcon);

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // idx is the logical key number; out-of-range indices are passed through unchanged.
    task automatic check_rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
`ifdef KEY_SCHED_REVERSE_READ_EN
        rd_idx = (idx <= 4'd10) ? 4'd10 - idx : idx;
`else
        rd_idx = idx;
`endif
        #1;
        check_eq(tag, rd_key, exp);
    endtask

    task automatic run_expand(input string tag, input logic [127:0] key, input bit inject,
                              input logic [127:0] mid_r1, input logic [127:0] mid_r10);
        @(negedge clk);
        key_in    = key;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            check_eq({tag, "_rcon"}, 128'(exp_rcon), 128'({rc_tab[r], 24'h0}));
            check_eq({tag, "_busy"}, 128'(busy), 128'(1'b1));
            check_eq({tag, "_done_early"}, 128'(done), 128'(1'b0));
            if (r == 3) begin
                check_rd({tag, "_mid_new1"}, 4'd1, mid_r1);
                check_rd({tag, "_mid_old10"}, 4'd10, mid_r10);
            end
            if (inject && r == 4) begin
                key_in    = ~key;
                key_valid = 1'b1;
            end
            @(posedge clk);
            #1 key_valid = 1'b0;
        end
        check_eq({tag, "_done"}, 128'(done), 128'(1'b1));
        check_eq({tag, "_busy_end"}, 128'(busy), 128'(1'b0));
        check_eq({tag, "_rcon_done"}, 128'(exp_rcon), 128'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check_eq("rst_busy", 128'(busy), 128'(1'b0));
        check_eq("rst_done", 128'(done), 128'(1'b0));
        check_eq("rst_exp_key", exp_key, '0);
        check_eq("rst_rcon", 128'(exp_rcon), 128'h0);
        check_rd("rst_rd0", 4'd0, '0);

        // key_valid while in reset must not start anything.
        key_in    = FipsKey;
        key_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_kv_ignored", 128'(busy), 128'(1'b0));
        key_valid = 1'b0;
        @(negedge clk) rst = 1'b0;

        run_expand("fips", FipsKey, 1'b0, FipsR1, '0);
        check_rd("fips_rd0", 4'd0, FipsKey);
        check_rd("fips_rd1", 4'd1, FipsR1);
        check_rd("fips_rd2", 4'd2, FipsR2);
        check_rd("fips_rd10", 4'd10, FipsR10);
        for (int i = 11; i <= 15; i++) begin
            check_rd($sformatf("fips_rd_oor%0d", i), 4'(i), '0);
        end
`ifdef KEY_SCHED_REVERSE_READ_EN
        rd_idx = 4'd0;
        #1 check_eq("rev_raw0", rd_key, FipsR10);
        rd_idx = 4'd10;
        #1 check_eq("rev_raw10", rd_key, FipsKey);
`endif

        // Restart from DONE with the zero key; a second strobe at cycle 4 must be ignored.
        run_expand("zero", '0, 1'b1, ZeroR1, FipsR10);
        check_rd("zero_rd0", 4'd0, '0);
        check_rd("zero_rd1", 4'd1, ZeroR1);
        check_rd("zero_rd2", 4'd2, ZeroR2);
        check_rd("zero_rd10", 4'd10, ZeroR10);

        // Asynchronous reset at cycle 5 of an expansion.
        @(negedge clk);
        key_in    = FipsKey;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", 128'(busy), 128'(1'b0));
        check_eq("abort_done", 128'(done), 128'(1'b0));
        check_eq("abort_exp_key", exp_key, '0);
        for (int i = 0; i <= 15; i++) begin
            rd_idx = 4'(i);
            #0.1;
            check_eq($sformatf("abort_rd%0d", i), rd_key, '0);
        end

        // Strobe held through reset release: capture on the first edge after deassertion.
        key_valid = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 key_valid = 1'b0;
        check_eq("post_rst_busy", 128'(busy), 128'(1'b1));
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_done", 128'(done), 128'(1'b1));
        check_rd("post_rst_rd1", 4'd1, FipsR1);
        check_rd("post_rst_rd10", 4'd10, FipsR10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
